// File: rtl/div_unit.sv
// Radix-2 restoring divider (DIV/DIVU) in Execute, acts as the stall source for the hazard unit.
// Latency: accept cycle + WIDTH iterations + one DONE cycle (divide-by-zero: accept + 1 + DONE).
// Backpressure: stall_o holds the pipeline from accept through the last iteration; annul_i aborts.
module div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic             signed_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             annul_i,
   output logic             stall_o,
   output logic             done_o,
   output logic [WIDTH-1:0] lo_o,
   output logic [WIDTH-1:0] hi_o,
   output logic             div_zero_o
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [1:0]    S_IDLE = 2'd0;
   localparam logic [1:0]    S_BUSY = 2'd1;
   localparam logic [1:0]    S_DONE = 2'd2;
   localparam logic [CW-1:0] LAST   = CW'(WIDTH - 1);

   logic [1:0]       state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] rem;      // partial remainder (magnitude)
   logic [WIDTH-1:0] quo;      // dividend shifts out the top, quotient bits shift in the bottom
   logic [WIDTH-1:0] dvs;      // divisor magnitude
   logic [WIDTH-1:0] raw_a;    // unmodified dividend, returned as remainder on divide-by-zero
   logic             sign_q;
   logic             sign_r;
   logic             zero;
   logic [WIDTH-1:0] lo_q;
   logic [WIDTH-1:0] hi_q;
   logic             dz_q;

   logic             accept;
   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;
   logic [WIDTH:0]   rem_sh;
   logic [WIDTH:0]   diff;
   logic             ge;
   logic [WIDTH-1:0] rem_nx;
   logic [WIDTH-1:0] quo_nx;

   assign accept  = (state == S_IDLE) && start_i && !annul_i;
   // BUSY keeps stalling even when annulled; the abort takes effect at the next edge.
   assign stall_o = accept || (state == S_BUSY);
   assign done_o  = (state == S_DONE);
   assign lo_o       = lo_q;
   assign hi_o       = hi_q;
   assign div_zero_o = dz_q;

   // Operand magnitudes and one restoring step; the shifted remainder needs one extra bit.
   always_comb begin
      a_mag  = (signed_i && a_i[WIDTH-1]) ? -a_i : a_i;
      b_mag  = (signed_i && b_i[WIDTH-1]) ? -b_i : b_i;
      rem_sh = {rem, quo[WIDTH-1]};
      diff   = rem_sh - {1'b0, dvs};
      ge     = (rem_sh >= {1'b0, dvs});
      rem_nx = ge ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
      quo_nx = {quo[WIDTH-2:0], ge};
   end

   // Control FSM, datapath registers and result registers (results load on entry to DONE).
   always_ff @(posedge clk) begin
      if (!rst) begin
         state  <= S_IDLE;
         cnt    <= '0;
         rem    <= '0;
         quo    <= '0;
         dvs    <= '0;
         raw_a  <= '0;
         sign_q <= 1'b0;
         sign_r <= 1'b0;
         zero   <= 1'b0;
         lo_q   <= '0;
         hi_q   <= '0;
         dz_q   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  state  <= S_BUSY;
                  cnt    <= '0;
                  rem    <= '0;
                  quo    <= a_mag;
                  dvs    <= b_mag;
                  raw_a  <= a_i;
                  sign_q <= signed_i && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
                  sign_r <= signed_i && a_i[WIDTH-1];
                  zero   <= (b_i == '0);
               end
            end
            S_BUSY: begin
               if (annul_i) begin
                  state <= S_IDLE;
               end else if (zero) begin
                  state <= S_DONE;
                  lo_q  <= '1;
                  hi_q  <= raw_a;
                  dz_q  <= 1'b1;
               end else begin
                  rem <= rem_nx;
                  quo <= quo_nx;
                  cnt <= cnt + CW'(1);
                  if (cnt == LAST) begin
                     state <= S_DONE;
                     lo_q  <= sign_q ? -quo_nx : quo_nx;
                     hi_q  <= sign_r ? -rem_nx : rem_nx;
                     dz_q  <= 1'b0;
                  end
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_div_unit.sv
// Bench for div_unit: directed cases plus random operands against an arithmetic reference.
// Each divide is timed cycle by cycle (stall_o, done_o position) and its results compared.
// Also covers annul in BUSY and in IDLE, mid-operation reset, and result hold after DONE.
module tb_div_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        start_i;
   logic        signed_i;
   logic [31:0] a_i;
   logic [31:0] b_i;
   logic        annul_i;
   logic        stall_o;
   logic        done_o;
   logic [31:0] lo_o;
   logic [31:0] hi_o;
   logic        div_zero_o;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] prev_lo  = '0;
   logic [31:0] prev_hi  = '0;
   logic        prev_dz  = 1'b0;

   div_unit #(.WIDTH(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .start_i    (start_i),
      .signed_i   (signed_i),
      .a_i        (a_i),
      .b_i        (b_i),
      .annul_i    (annul_i),
      .stall_o    (stall_o),
      .done_o     (done_o),
      .lo_o       (lo_o),
      .hi_o       (hi_o),
      .div_zero_o (div_zero_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference: plain 64-bit arithmetic; SV signed / and % truncate toward zero.
   task automatic model(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] lo, output logic [31:0] hi, output logic dz);
      longint x;
      longint y;
      if (b == 32'd0) begin
         lo = 32'hFFFF_FFFF;
         hi = a;
         dz = 1'b1;
      end else begin
         if (sgn) begin
            x = longint'($signed(a));
            y = longint'($signed(b));
         end else begin
            x = longint'({32'd0, a});
            y = longint'({32'd0, b});
         end
         lo = 32'(x / y);
         hi = 32'(x % y);
         dz = 1'b0;
      end
   endtask

   // Idle cycles with start low: no done pulse, no stall, results held.
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         start_i = 1'b0;
         annul_i = 1'b0;
         #1;
         chk("idle_done", 32'(done_o), 32'd0);
         chk("idle_stall", 32'(stall_o), 32'd0);
         chk("hold_lo", lo_o, prev_lo);
         chk("hold_hi", hi_o, prev_hi);
         chk("hold_dz", 32'(div_zero_o), 32'(prev_dz));
      end
   endtask

   // One divide. abort_at > 0 cancels at that cycle (annul, or reset when use_rst).
   // Returns just after the DONE-cycle sample with start_i still high.
   task automatic run_div(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                          input int abort_at, input bit use_rst);
      logic [31:0] elo;
      logic [31:0] ehi;
      logic        edz;
      int          lat;
      int          cyc;
      int          seen;
      model(sgn, a, b, elo, ehi, edz);
      lat = (b == 32'd0) ? 2 : 33;
      @(negedge clk);
      start_i  = 1'b1;
      signed_i = sgn;
      a_i      = a;
      b_i      = b;
      annul_i  = 1'b0;
      #1;
      chk("stall_accept", 32'(stall_o), 32'd1);
      cyc = 0;
      while (cyc < 40) begin
         @(negedge clk);
         cyc++;
         a_i      = $urandom;
         b_i      = $urandom;
         signed_i = 1'($urandom);
         #1;
         if (cyc == abort_at) begin
            if (use_rst) begin
               rst     = 1'b0;
               start_i = 1'b0;
               @(negedge clk);
               #1;
               chk("rst_stall", 32'(stall_o), 32'd0);
               chk("rst_done", 32'(done_o), 32'd0);
               chk("rst_lo", lo_o, 32'd0);
               chk("rst_hi", hi_o, 32'd0);
               chk("rst_dz", 32'(div_zero_o), 32'd0);
               rst = 1'b1;
               prev_lo = '0;
               prev_hi = '0;
               prev_dz = 1'b0;
               seen = 0;
               for (int i = 0; i < 40; i++) begin
                  @(negedge clk);
                  #1;
                  if (done_o) seen++;
               end
               chk("no_done_after_rst", 32'(seen), 32'd0);
            end else begin
               annul_i = 1'b1;
               #1;
               chk("annul_busy_stall", 32'(stall_o), 32'd1);
               @(negedge clk);
               annul_i = 1'b0;
               start_i = 1'b0;
               #1;
               chk("annul_next_stall", 32'(stall_o), 32'd0);
               chk("annul_next_done", 32'(done_o), 32'd0);
               chk("annul_lo_kept", lo_o, prev_lo);
               chk("annul_hi_kept", hi_o, prev_hi);
               chk("annul_dz_kept", 32'(div_zero_o), 32'(prev_dz));
            end
            return;
         end
         if (done_o) break;
         chk("stall_busy", 32'(stall_o), 32'd1);
      end
      chk("done_cycle", 32'(cyc), 32'(lat));
      chk("done_stall", 32'(stall_o), 32'd0);
      chk("lo", lo_o, elo);
      chk("hi", hi_o, ehi);
      chk("div_zero", 32'(div_zero_o), 32'(edz));
      prev_lo = elo;
      prev_hi = ehi;
      prev_dz = edz;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] ra;
      logic [31:0] rb;
      int          sel;
      rst      = 1'b0;
      start_i  = 1'b0;
      signed_i = 1'b0;
      a_i      = '0;
      b_i      = '0;
      annul_i  = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk("reset_stall", 32'(stall_o), 32'd0);
      chk("reset_done", 32'(done_o), 32'd0);
      chk("reset_lo", lo_o, 32'd0);
      chk("reset_hi", hi_o, 32'd0);
      chk("reset_dz", 32'(div_zero_o), 32'd0);
      rst = 1'b1;
      idle(1);

      // DIVU 100/7, then results hold after DONE
      run_div(1'b0, 32'd100, 32'd7, 0, 1'b0);
      idle(2);
      // signed sign rules
      run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 0, 1'b0);
      idle(1);
      run_div(1'b1, 32'd7, 32'hFFFF_FFFE, 0, 1'b0);
      idle(1);
      // overflow, then divide by zero
      run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
      idle(1);
      run_div(1'b0, 32'd5, 32'd0, 0, 1'b0);
      idle(1);
      run_div(1'b1, 32'hFFFF_FFF0, 32'd0, 0, 1'b0);
      idle(1);

      // annul at cycle 10, fresh divide accepted at cycle 12
      run_div(1'b0, 32'd100, 32'd7, 10, 1'b0);
      run_div(1'b0, 32'd9, 32'd3, 0, 1'b0);
      idle(1);

      // back-to-back: start held through DONE, second accepted the next cycle
      run_div(1'b0, 32'd100, 32'd7, 0, 1'b0);
      run_div(1'b0, 32'd50, 32'd5, 0, 1'b0);
      idle(1);

      // annul in IDLE blocks the accept
      @(negedge clk);
      start_i = 1'b1;
      annul_i = 1'b1;
      a_i = 32'd10;
      b_i = 32'd3;
      #1;
      chk("annul_idle_stall", 32'(stall_o), 32'd0);
      idle(2);

      // reset at cycle 15 of an operation
      run_div(1'b0, 32'd100, 32'd7, 15, 1'b1);
      idle(1);

      // random operands, mixed signedness
      for (int k = 0; k < 16; k++) begin
         sel = $urandom_range(0, 9);
         ra  = $urandom;
         rb  = $urandom;
         if (sel == 0) rb = 32'd0;
         else if (sel < 4) rb = 32'($urandom_range(1, 20)) ^ ({32{rb[31]}} & 32'hFFFF_FFFF);
         if (sel == 5) ra = 32'($urandom_range(0, 100));
         run_div(1'($urandom), ra, rb, 0, 1'b0);
         idle(1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle radix-2 restoring divider for DIV/DIVU, sitting in the Execute stage beside the ALU.
- Acts as the stall requester toward the hazard unit: it raises stall_o while a division is in flight, and the hazard unit folds this into its F/D/E stall.
- On completion it presents quotient (LO) and remainder (HI) for one cycle so the instruction advances and writes HILO through the normal pipeline.

Parameters:
WIDTH  32  operand/result width in bits

Ports:
clk         input   1      clock, all state updates on rising edge
rst         input   1      synchronous reset, active-low
start_i     input   1      Execute-stage instruction is DIV/DIVU; held high while stalled
signed_i    input   1      1 = DIV (two's complement), 0 = DIVU; sampled with start_i
a_i         input   WIDTH  dividend (rs value after forwarding)
b_i         input   WIDTH  divisor (rt value after forwarding)
annul_i     input   1      Execute-stage flush/exception; cancels any operation
stall_o     output  1      stall request to hazard unit
done_o      output  1      one-cycle pulse; hi_o/lo_o/div_zero_o valid
lo_o        output  WIDTH  quotient
hi_o        output  WIDTH  remainder
div_zero_o  output  1      last completed operation had divisor 0

Behaviour:
- Reset (rst=0 at an edge): state=IDLE, counter=0; stall_o=0, done_o=0, lo_o=0, hi_o=0, div_zero_o=0. Reset overrides an in-flight operation; no done pulse is produced.
- States and transitions:
  - IDLE -> BUSY on start_i & ~annul_i.
  - BUSY -> DONE after WIDTH iterations.
  - BUSY -> IDLE on annul_i.
  - DONE -> IDLE unconditionally.
  - Any state -> IDLE on annul_i.
- Accept (IDLE, start_i & ~annul_i):
  - Latch sign_q = signed_i & (a_i[MSB] ^ b_i[MSB]) and sign_r = signed_i & a_i[MSB].
  - Latch magnitudes |a|, |b|; unsigned operands are taken as-is.
  - Clear the partial remainder; counter=0.
  - Latch zero flag = (b_i==0).
- BUSY iteration, one bit per cycle, MSB first:
  - rem' = {rem, q[MSB]}, q' = q<<1.
  - If rem' >= |b|: rem' -= |b| and q'[0] = 1.
  - counter increments; leave BUSY when counter reaches WIDTH-1 completes (WIDTH iterations total).
- Divisor zero: skip iterations, BUSY lasts exactly one cycle, then DONE with lo_o = all ones, hi_o = a_i (raw), div_zero_o = 1.
- DONE cycle:
  - done_o=1.
  - lo_o = sign_q ? -q : q; hi_o = sign_r ? -rem : rem; div_zero_o = zero flag.
  - Outputs are registered on entry to DONE and hold after DONE until the next accept.
  - Sign rule: quotient truncates toward zero; remainder takes the dividend's sign.
- Overflow: signed 0x80000000 / 0xFFFFFFFF gives lo_o=0x80000000, hi_o=0, div_zero_o=0. This falls out naturally from magnitude arithmetic and needs no special case.
- stall_o (combinational) = (IDLE & start_i & ~annul_i) | BUSY.
  - Low in DONE, so the instruction leaves Execute at the end of the DONE cycle.
  - Low whenever state is IDLE and annul_i=1.
- Latency: accept at cycle 0, iterations at cycles 1..WIDTH, done_o at cycle WIDTH+1. stall_o is high during cycles 0..WIDTH (WIDTH+1 cycles). Divide-by-zero: done_o at cycle 2.
- start_i during DONE is ignored (same instruction departing). A new start_i in the following IDLE cycle is accepted, so back-to-back divides have a one-cycle gap.
- annul_i in BUSY: stall_o stays high that cycle, then state=IDLE next cycle. No done_o pulse; hi_o/lo_o/div_zero_o retain their previous values.
- annul_i in DONE: done_o is still asserted that cycle. The pipeline flush discards the writeback.
- Operand changes on a_i/b_i after accept are ignored.

Test Plan:
1. DIVU a=100, b=7, start held -> stall_o high cycles 0..32, done_o at cycle 33 with lo_o=14, hi_o=2, div_zero_o=0; stall_o=0 at cycle 33.
2. DIV a=0xFFFFFFF9 (-7), b=2 -> lo_o=0xFFFFFFFD (-3), hi_o=0xFFFFFFFF (-1); also DIV 7/-2 -> lo_o=0xFFFFFFFD, hi_o=1.
3. DIV a=0x80000000, b=0xFFFFFFFF -> lo_o=0x80000000, hi_o=0; then DIVU a=5, b=0 -> done_o at cycle 2, lo_o=0xFFFFFFFF, hi_o=5, div_zero_o=1.
4. DIVU 100/7, annul_i pulsed at cycle 10 -> state IDLE at cycle 11, stall_o=0 at cycle 11, no done_o, hi_o/lo_o unchanged; new DIVU 9/3 at cycle 12 -> done_o at cycle 45, lo_o=3, hi_o=0.
5. Back-to-back: DIVU 100/7, then start_i re-asserted the cycle after done_o with 50/5 -> second done_o 34 cycles after the first, lo_o=10, hi_o=0; start_i during DONE not accepted.
6. rst=0 at cycle 15 of an operation -> next cycle stall_o=0, done_o=0, lo_o=hi_o=0, div_zero_o=0; no done pulse follows.
